// File: rtl/pc_branch_unit.sv
// Program-counter stage: sequential, taken-branch and jump next-PC with flush.
// Optional PC_BRANCH_COUNT_EN adds a saturating redirect counter port.
module pc_branch_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INC      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic             branch_cond,
    input  logic [WIDTH-1:0] offset_shifted,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_decode,
    output logic             fetch_valid,
    output logic             flush
`ifdef PC_BRANCH_COUNT_EN
    ,
    output logic [15:0]      branch_count
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_decode_d;
    logic             redirect;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc;
        pc_decode_d = pc_decode;
        redirect    = 1'b0;
        if (!stall) begin
            unique case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    pc_decode_d = pc;
                    if (jump_valid) begin
                        pc_d     = jump_target;
                        redirect = 1'b1;
                    end else if (branch_valid && branch_cond) begin
                        pc_d     = pc_decode + INC_W + offset_shifted;
                        redirect = 1'b1;
                    end else begin
                        pc_d = pc + INC_W;
                    end
                    if (redirect) begin
                        state_d = FLUSH;
                    end
                end
                // Decode slot is squashed here, so redirect inputs are ignored.
                FLUSH: begin
                    pc_decode_d = pc;
                    pc_d        = pc + INC_W;
                    state_d     = RUN;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT;
            pc        <= RESET_PC;
            pc_decode <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            pc_decode <= pc_decode_d;
        end
    end

    assign fetch_valid = (state_q != BOOT);
    assign flush       = (state_q == FLUSH);

`ifdef PC_BRANCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count <= 16'h0000;
        end else if (redirect && branch_count != 16'hFFFF) begin
            branch_count <= branch_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit.
// Counter checks are compiled in only with PC_BRANCH_COUNT_EN.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_valid;
    logic        branch_cond;
    logic [15:0] offset_shifted;
    logic        jump_valid;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic [15:0] pc_decode;
    logic        fetch_valid;
    logic        flush;
`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] branch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_branch_unit #(
        .WIDTH(16),
        .RESET_PC(16'h0000),
        .INC(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_valid(branch_valid),
        .branch_cond(branch_cond),
        .offset_shifted(offset_shifted),
        .jump_valid(jump_valid),
        .jump_target(jump_target),
        .pc(pc),
        .pc_decode(pc_decode),
        .fetch_valid(fetch_valid),
        .flush(flush)
`ifdef PC_BRANCH_COUNT_EN
        ,
        .branch_count(branch_count)
`endif
    );

    // Advance one rising edge; outputs are then sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stall          = 1'b0;
        branch_valid   = 1'b0;
        branch_cond    = 1'b0;
        offset_shifted = 16'h0000;
        jump_valid     = 1'b0;
        jump_target    = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        checks++;
        if (pc !== 16'h0000 || pc_decode !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc pc=%h dec=%h want 0000/0000", pc, pc_decode);
        end
        checks++;
        if (fetch_valid !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl fv=%b fl=%b want 0/0", fetch_valid, flush);
        end
`ifdef PC_BRANCH_COUNT_EN
        checks++;
        if (branch_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt got=%h want 0000", branch_count);
        end
`endif
        cyc();
        checks++;
        if (pc !== 16'h0000 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot_exit pc=%h fv=%b want 0000/1", pc, fetch_valid);
        end
        cyc();
        checks++;
        if (pc !== 16'h0002) begin
            errors++;
            $display("FAIL seq1 got=%h want 0002", pc);
        end
        cyc();
        checks++;
        if (pc !== 16'h0004 || pc_decode !== 16'h0002) begin
            errors++;
            $display("FAIL seq2 pc=%h dec=%h want 0004/0002", pc, pc_decode);
        end
    endtask

    task automatic test_branch_fwd();
        repeat (7) cyc();
        checks++;
        if (pc !== 16'h0012 || pc_decode !== 16'h0010) begin
            errors++;
            $display("FAIL fwd_setup pc=%h dec=%h want 0012/0010", pc, pc_decode);
        end
        branch_valid   = 1'b1;
        branch_cond    = 1'b1;
        offset_shifted = 16'h0008;
        cyc();
        clear_inputs();
        checks++;
        if (pc !== 16'h001A || flush !== 1'b1) begin
            errors++;
            $display("FAIL fwd_target pc=%h fl=%b want 001a/1", pc, flush);
        end
`ifdef PC_BRANCH_COUNT_EN
        checks++;
        if (branch_count !== 16'h0001) begin
            errors++;
            $display("FAIL fwd_cnt got=%h want 0001", branch_count);
        end
`endif
        cyc();
        checks++;
        if (pc !== 16'h001C || flush !== 1'b0 || pc_decode !== 16'h001A) begin
            errors++;
            $display("FAIL fwd_after pc=%h fl=%b dec=%h want 001c/0/001a",
                     pc, flush, pc_decode);
        end
    endtask

    task automatic test_branch_back();
        repeat (3) cyc();
        checks++;
        if (pc !== 16'h0022 || pc_decode !== 16'h0020) begin
            errors++;
            $display("FAIL back_setup pc=%h dec=%h want 0022/0020", pc, pc_decode);
        end
        branch_valid   = 1'b1;
        branch_cond    = 1'b1;
        offset_shifted = 16'hFFF0;
        cyc();
        clear_inputs();
        checks++;
        if (pc !== 16'h0012 || flush !== 1'b1) begin
            errors++;
            $display("FAIL back_target pc=%h fl=%b want 0012/1", pc, flush);
        end
        cyc();
        checks++;
        if (pc !== 16'h0014 || flush !== 1'b0) begin
            errors++;
            $display("FAIL back_after pc=%h fl=%b want 0014/0", pc, flush);
        end
    endtask

    task automatic test_jump_priority();
        jump_valid     = 1'b1;
        jump_target    = 16'h0400;
        branch_valid   = 1'b1;
        branch_cond    = 1'b1;
        offset_shifted = 16'h0008;
        cyc();
        checks++;
        if (pc !== 16'h0400 || flush !== 1'b1) begin
            errors++;
            $display("FAIL jump_target pc=%h fl=%b want 0400/1", pc, flush);
        end
        // Inputs left asserted: they must be ignored while flushing.
        cyc();
        clear_inputs();
        checks++;
        if (pc !== 16'h0402 || flush !== 1'b0) begin
            errors++;
            $display("FAIL jump_one_flush pc=%h fl=%b want 0402/0", pc, flush);
        end
`ifdef PC_BRANCH_COUNT_EN
        checks++;
        if (branch_count !== 16'h0003) begin
            errors++;
            $display("FAIL jump_cnt got=%h want 0003", branch_count);
        end
`endif
    endtask

    task automatic test_stall();
        stall          = 1'b1;
        branch_valid   = 1'b1;
        branch_cond    = 1'b1;
        offset_shifted = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (pc !== 16'h0402 || pc_decode !== 16'h0400 || flush !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d pc=%h dec=%h fl=%b want 0402/0400/0",
                         i, pc, pc_decode, flush);
            end
        end
        stall = 1'b0;
        cyc();
        checks++;
        if (pc !== 16'h0412 || flush !== 1'b1) begin
            errors++;
            $display("FAIL stall_release pc=%h fl=%b want 0412/1", pc, flush);
        end
        clear_inputs();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (pc !== 16'h0412 || flush !== 1'b1) begin
                errors++;
                $display("FAIL stall_flush%0d pc=%h fl=%b want 0412/1", i, pc, flush);
            end
        end
        stall = 1'b0;
        cyc();
        checks++;
        if (pc !== 16'h0414 || flush !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush_exit pc=%h fl=%b want 0414/0", pc, flush);
        end
`ifdef PC_BRANCH_COUNT_EN
        checks++;
        if (branch_count !== 16'h0004) begin
            errors++;
            $display("FAIL stall_cnt got=%h want 0004", branch_count);
        end
`endif
    endtask

    task automatic test_wrap();
        jump_valid  = 1'b1;
        jump_target = 16'hFFFC;
        cyc();
        clear_inputs();
        cyc();
        checks++;
        if (pc !== 16'hFFFE || flush !== 1'b0) begin
            errors++;
            $display("FAIL wrap_setup pc=%h fl=%b want fffe/0", pc, flush);
        end
        cyc();
        checks++;
        if (pc !== 16'h0000 || pc_decode !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap pc=%h dec=%h want 0000/fffe", pc, pc_decode);
        end
    endtask

    task automatic test_reset_mid_flush();
        jump_valid  = 1'b1;
        jump_target = 16'h0100;
        cyc();
        checks++;
        if (pc !== 16'h0100 || flush !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup pc=%h fl=%b want 0100/1", pc, flush);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (pc !== 16'h0000 || flush !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush pc=%h fl=%b fv=%b want 0000/0/0",
                     pc, flush, fetch_valid);
        end
`ifdef PC_BRANCH_COUNT_EN
        checks++;
        if (branch_count !== 16'h0000) begin
            errors++;
            $display("FAIL rst_cnt got=%h want 0000", branch_count);
        end
`endif
        reset = 1'b0;
        clear_inputs();
        cyc();
    endtask

    task automatic test_not_taken();
        branch_valid   = 1'b1;
        branch_cond    = 1'b0;
        offset_shifted = 16'h0008;
        cyc();
        checks++;
        if (pc !== 16'h0002 || flush !== 1'b0) begin
            errors++;
            $display("FAIL not_taken pc=%h fl=%b want 0002/0", pc, flush);
        end
        cyc();
        clear_inputs();
        checks++;
        if (pc !== 16'h0004 || flush !== 1'b0) begin
            errors++;
            $display("FAIL not_taken2 pc=%h fl=%b want 0004/0", pc, flush);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_branch_fwd();
        test_branch_back();
        test_jump_priority();
        test_stall();
        test_wrap();
        test_reset_mid_flush();
        test_not_taken();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
